sparse_match_scanner: RTL and testbench
=======================================

# sparse_match_scanner

Multi-lane successor to the single-address match encoder in the sparse datapath. It takes one IFM/filter bitmap pair per handshake and ANDs the two bitmaps into a match mask. It then streams the addresses of all set bits in ascending order, up to `LANES` addresses per output beat, and flags the last beat with a running match count. It sits between the bitmap fetch stage and the MAC operand-gather stage, with valid/ready backpressure on both sides.

## Interface
Parameters:
- `SIZE`, default 128: bitmap width. Power of two, at least 4.
- `LANES`, default 2: maximum addresses per output beat. Range 1 to 8, and at most `SIZE`.
- `AW`, localparam, equal to $clog2(SIZE): address width.

Ports:
- `clk_i`, input, 1: clock, rising edge.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `in_valid_i`, input, 1: bitmap pair valid.
- `in_ready_o`, output, 1: block can accept a pair.
- `in1_i`, input, `SIZE`: IFM bitmap.
- `in2_i`, input, `SIZE`: filter bitmap.
- `out_valid_o`, output, 1: beat valid.
- `out_ready_i`, input, 1: consumer accepts the beat.
- `out_addr_o`, output, `LANES*AW`: lane k occupies bits [k*AW +: AW]. Lane 0 holds the lowest address.
- `out_mask_o`, output, `LANES`: per-lane valid. Always packed from lane 0 upward.
- `out_last_o`, output, 1: final beat for the current pair.
- `match_cnt_o`, output, `AW+1`: matches emitted so far for this pair, including the current beat.

## Operation
- States:
  - IDLE: `out_valid_o`=0.
  - SCAN: `out_valid_o`=1.
- Input handshake:
  - Fires when `in_valid_i && in_ready_o`.
  - Registers `mask_r <= in1_i & in2_i`, clears `cnt_r`, and moves to SCAN.
- Beat contents in SCAN:
  - The `LANES` lowest set bits of `mask_r` go to lanes 0 upward in ascending order.
  - `out_mask_o` has one bit per found bit.
  - Unused lanes drive address 0.
- `out_last_o` = 1 when `mask_r` has no set bits beyond those presented in the current beat.
- `match_cnt_o` = `cnt_r` + popcount(`out_mask_o`). The value on the last beat is the total popcount of `in1_i & in2_i`.
- Output handshake fires when `out_valid_o && out_ready_i`:
  - Clears the presented bits in `mask_r`.
  - Sets `cnt_r <= match_cnt_o`.
  - If `out_last_o`=1, returns to IDLE, unless a new input is accepted in the same cycle; in that case it stays in SCAN with the new mask.
- Empty mask (`in1_i & in2_i` = 0): exactly one beat is emitted, with `out_mask_o`=0, `out_last_o`=1, `match_cnt_o`=0. The consumer always receives an end marker.
- Beats per pair = max(1, ceil(popcount/`LANES`)).
- `in_ready_o` = IDLE || (`out_valid_o && out_ready_i && out_last_o`). This is a combinational path from `out_ready_i`, which is permitted and documented for integration.
- While `out_valid_o`=1 and `out_ready_i`=0, all `out_*` and `match_cnt_o` hold stable. Internal state does not change.

## Timing
- Reset (`rst_ni` low, asynchronous):
  - State goes to IDLE; `mask_r` and `cnt_r` go to 0.
  - `out_valid_o`=0, `out_mask_o`=0, `out_addr_o`=0, `out_last_o`=0, `match_cnt_o`=0.
  - `in_ready_o`=0 while `rst_ni` is low, and 1 from the first edge after deassertion.
- Latency: a pair accepted at edge N produces its first beat valid after edge N, i.e. in cycle N+1.
- Throughput:
  - One beat per cycle with `out_ready_i` held high.
  - Back-to-back pairs have no bubble: a new pair is accepted on the last-beat handshake edge, and its first beat is valid in the next cycle.
- Lane extraction is combinational from `mask_r`, using `LANES` cascaded priority encoders or an equivalent structure. It must close timing at `SIZE`=128, `LANES`=2.
- Reset mid-SCAN aborts the pair immediately. No further beats for it are emitted after reset is released.
- `in1_i`/`in2_i` are sampled only on the input handshake edge. Changes at other times have no effect.

## Test plan
- `SIZE`=16, `LANES`=2, `in1_i`=0xF0F0, `in2_i`=0x3C3C (mask 0x3030), ready held high:
  - Beat 1: addrs {4,5}, mask 2'b11, last 0, cnt 2.
  - Beat 2: addrs {12,13}, mask 2'b11, last 1, cnt 4.
  - Then IDLE.
- Empty pair, `in1_i`=0x00FF, `in2_i`=0xFF00: one beat with mask 2'b00, last 1, cnt 0, one cycle after acceptance.
- Odd count, mask 0x8009:
  - Beat 1: lanes {0,3}, mask 2'b11, cnt 2.
  - Beat 2: lane0=15, lane1=0, mask 2'b01, last 1, cnt 3.
- Backpressure: `out_ready_i` low for 3 cycles during beat 1 of 0x3030. All outputs stay constant, `in_ready_o`=0, and the beat sequence is unchanged after release.
- Back-to-back: pair B (mask 0x0001) is presented while A's last beat is handshaken.
  - `in_ready_o`=1 on that cycle.
  - B's beat (addr 0, mask 2'b01, last 1, cnt 1) is valid on the next cycle, with no idle cycle.
- Reset mid-scan: assert `rst_ni` low asynchronously after beat 1 of 0x3030.
  - Outputs go to 0 immediately.
  - After release, `in_ready_o`=1 and no beat for 0x3030 appears.
  - A new pair then scans correctly.

Source files
------------

// File: rtl/sparse_match_scanner.sv
// Streams the ascending addresses of set bits in (in1 & in2), up to LANES per beat,
// with a running match count and a last-beat marker.
module sparse_match_scanner #(
    parameter  int SIZE  = 128,
    parameter  int LANES = 2,
    localparam int AW    = $clog2(SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [SIZE-1:0]       in1_i,
    input  logic [SIZE-1:0]       in2_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES*AW-1:0]   out_addr_o,
    output logic [LANES-1:0]      out_mask_o,
    output logic                  out_last_o,
    output logic [AW:0]           match_cnt_o
);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, SCAN} state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] mask_q, mask_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_en_q;

    logic [SIZE-1:0] rem [LANES+1];
    logic [LANES-1:0] found;
    logic [CW-1:0]   beat_cnt;
    logic            scan;
    logic            in_fire;
    logic            out_fire;

    function automatic logic [AW-1:0] lsb_index(input logic [SIZE-1:0] v);
        lsb_index = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (v[i]) lsb_index = AW'(i);
        end
    endfunction

    // Each stage peels the lowest set bit off the remainder handed down by the previous lane.
    assign rem[0] = mask_q;
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign found[gi]                 = |rem[gi];
            assign out_addr_o[gi*AW +: AW]   = lsb_index(rem[gi]);
            assign rem[gi+1]                 = rem[gi] & (rem[gi] - SIZE'(1));
        end
    endgenerate

    always_comb begin
        beat_cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_cnt = beat_cnt + CW'(found[k]);
        end
    end

    assign scan        = (state_q == SCAN);
    assign out_valid_o = scan;
    assign out_mask_o  = found;
    assign out_last_o  = scan && (rem[LANES] == '0);
    assign match_cnt_o = scan ? (cnt_q + beat_cnt) : '0;

    // ready_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready_o = ready_en_q && (!scan || (out_ready_i && out_last_o));
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = scan && out_ready_i;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        if (in_fire) begin
            state_d = SCAN;
            mask_d  = in1_i & in2_i;
            cnt_d   = '0;
        end else if (out_fire) begin
            mask_d = rem[LANES];
            cnt_d  = match_cnt_o;
            if (out_last_o) state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sparse_match_scanner.sv
// Directed bench for sparse_match_scanner with a per-cycle beat-queue model.
module tb_sparse_match_scanner;
    localparam int SIZE = 16;
    localparam int L    = 2;
    localparam int AW   = $clog2(SIZE);

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [SIZE-1:0] in1 = '0;
    logic [SIZE-1:0] in2 = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [L*AW-1:0] out_addr;
    logic [L-1:0]    out_mask;
    logic            out_last;
    logic [AW:0]     match_cnt;

    int tests = 0;
    int fails = 0;

    sparse_match_scanner #(.SIZE(SIZE), .LANES(L)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in1_i(in1), .in2_i(in2),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_addr_o(out_addr), .out_mask_o(out_mask),
        .out_last_o(out_last), .match_cnt_o(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [L*AW-1:0] addr;
        logic [L-1:0]    mask;
        logic            last;
        logic [AW:0]     cnt;
    } beat_t;

    beat_t q[$];
    logic  armed;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) armed <= 1'b0;
        else         armed <= 1'b1;
    end

    task automatic push_pair(input logic [SIZE-1:0] m);
        int    idx[$];
        beat_t b;
        for (int i = 0; i < SIZE; i++) if (m[i]) idx.push_back(i);
        if (idx.size() == 0) begin
            b.addr = '0; b.mask = '0; b.last = 1'b1; b.cnt = '0;
            q.push_back(b);
        end else begin
            for (int j = 0; j < idx.size(); j += L) begin
                b.addr = '0; b.mask = '0;
                for (int k = 0; k < L; k++) begin
                    if (j + k < idx.size()) begin
                        b.addr[k*AW +: AW] = AW'(idx[j+k]);
                        b.mask[k] = 1'b1;
                    end
                end
                b.last = (j + L >= idx.size());
                b.cnt  = (AW+1)'(b.last ? idx.size() : j + L);
                q.push_back(b);
            end
        end
    endtask

    always @(negedge clk) begin
        logic exp_ready;
        if (!rst_ni) begin
            q.delete();
        end else begin
            chk("m_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("m_addr", 64'(out_addr), 64'(q[0].addr));
                chk("m_mask", 64'(out_mask), 64'(q[0].mask));
                chk("m_last", 64'(out_last), 64'(q[0].last));
                chk("m_cnt",  64'(match_cnt), 64'(q[0].cnt));
            end
            exp_ready = armed && ((q.size() == 0) || (q[0].last && out_ready));
            chk("m_in_ready", 64'(in_ready), 64'(exp_ready));
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) push_pair(in1 & in2);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic expect_beat(input string nm, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [L-1:0] m, input logic lst, input logic [AW:0] c);
        logic [L*AW-1:0] ea;
        ea = {a1, a0};
        @(negedge clk);
        $display("[TB] %s: addr=%0h mask=%0b last=%0b cnt=%0d", nm, out_addr, out_mask, out_last, match_cnt);
        chk({nm, "_valid"}, 64'(out_valid), 64'(1));
        chk({nm, "_addr"},  64'(out_addr),  64'(ea));
        chk({nm, "_mask"},  64'(out_mask),  64'(m));
        chk({nm, "_last"},  64'(out_last),  64'(lst));
        chk({nm, "_cnt"},   64'(match_cnt), 64'(c));
    endtask

    task automatic present(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        in_valid = 1'b1; in1 = a; in2 = b;
        tick();
        in_valid = 1'b0; in1 = 16'hFFFF; in2 = 16'hFFFF;
    endtask

    task automatic expect_idle(input string nm);
        @(negedge clk);
        $display("[TB] %s: valid=%0b in_ready=%0b", nm, out_valid, in_ready);
        chk(nm, 64'(out_valid), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(0));
        chk("rst_outs",  64'({out_addr, out_mask, out_last, match_cnt}), 64'(0));
        tick(); tick();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("ready_pre_edge", 64'(in_ready), 64'(0));
        tick();
        @(negedge clk);
        chk("ready_post_edge", 64'(in_ready), 64'(1));
        tick();

        // 0x3030 over two beats
        present(16'hF0F0, 16'h3C3C);
        expect_beat("p1_b1", 4, 5, 2'b11, 1'b0, 2);
        tick();
        expect_beat("p1_b2", 12, 13, 2'b11, 1'b1, 4);
        tick();
        expect_idle("p1_idle");
        tick();

        // Empty pair still yields an end marker
        present(16'h00FF, 16'hFF00);
        expect_beat("empty", 0, 0, 2'b00, 1'b1, 0);
        tick();
        expect_idle("empty_idle");
        tick();

        // Odd count
        present(16'h8009, 16'hFFFF);
        expect_beat("odd_b1", 0, 3, 2'b11, 1'b0, 2);
        tick();
        expect_beat("odd_b2", 15, 0, 2'b01, 1'b1, 3);
        tick();

        // Backpressure on beat 1
        out_ready = 1'b0;
        present(16'h3030, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            expect_beat("bp_hold", 4, 5, 2'b11, 1'b0, 2);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            tick();
        end
        out_ready = 1'b1;
        expect_beat("bp_b1", 4, 5, 2'b11, 1'b0, 2);
        tick();
        expect_beat("bp_b2", 12, 13, 2'b11, 1'b1, 4);
        tick();

        // Back-to-back: B accepted on A's last-beat handshake
        present(16'h3030, 16'hFFFF);
        expect_beat("b2b_a1", 4, 5, 2'b11, 1'b0, 2);
        tick();
        in_valid = 1'b1; in1 = 16'h0001; in2 = 16'h0001;
        expect_beat("b2b_a2", 12, 13, 2'b11, 1'b1, 4);
        chk("b2b_in_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0; in1 = '0; in2 = '0;
        expect_beat("b2b_b", 0, 0, 2'b01, 1'b1, 1);
        tick();
        expect_idle("b2b_idle");
        tick();

        // Reset mid-scan
        present(16'h3030, 16'hFFFF);
        expect_beat("rs_b1", 4, 5, 2'b11, 1'b0, 2);
        #2 rst_ni = 1'b0;
        #1;
        $display("[TB] rst_mid: valid=%0b mask=%0b last=%0b cnt=%0d", out_valid, out_mask, out_last, match_cnt);
        chk("rs_async", 64'({out_valid, out_addr, out_mask, out_last, match_cnt}), 64'(0));
        chk("rs_ready", 64'(in_ready), 64'(0));
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_idle("rs_no_beat");
            chk("rs_ready_after", 64'(in_ready), 64'(1));
            tick();
        end
        present(16'h8009, 16'hFFFF);
        expect_beat("rs_new_b1", 0, 3, 2'b11, 1'b0, 2);
        tick();
        expect_beat("rs_new_b2", 15, 0, 2'b01, 1'b1, 3);
        tick();
        expect_idle("rs_new_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
